text_tile_gen: RTL and testbench

- Parametrised text-mode tile generator. It converts the pixel coordinates from the VGA sync block into text RGB.
- Tile map is MAX_X x MAX_Y cells of 8x16 glyphs, read through the existing font_rom.
- Each cell stores a 7-bit character code plus per-cell foreground and background colour.
- Characters arrive through a valid/ready write stream that carries a hardware cursor, control codes and a clear-screen engine.

---
 rtl/text_tile_gen.sv | 183 ++++++++++++++++++
 tb/tb_text_tile_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/text_tile_gen.sv
// text_tile_gen: text-mode tile generator turning VGA pixel coordinates into text colour
// Optional feature macro CURSOR_BLINK_EN: blinking cursor paced by frame_tick.
// Ports: clk, reset (async, active-high); video_on, pixel_x, pixel_y, frame_tick from the sync block;
//        wr_valid/wr_ready/wr_char/wr_fg/wr_bg write stream; mv_right/mv_down cursor ticks;
//        cur_x, cur_y cursor position; busy clear engine active; rgb_text registered pixel colour.
module font_rom (
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  always_comb begin
    data = 8'h00;
    case (addr)
      11'h412: data = 8'h10;
      11'h413: data = 8'h38;
      11'h414: data = 8'h6c;
      11'h415, 11'h416, 11'h418, 11'h419, 11'h41a, 11'h41b: data = 8'hc6;
      11'h417: data = 8'hfe;
      11'h422, 11'h42b: data = 8'hfc;
      11'h423, 11'h424, 11'h425, 11'h427, 11'h428, 11'h429, 11'h42a: data = 8'h66;
      11'h426: data = 8'h7c;
      default: data = 8'h00;
    endcase
  end
endmodule

module text_tile_gen #(
  parameter int MAX_X = 80,
  parameter int MAX_Y = 30,
  parameter int RGB_W = 3,
  parameter logic [RGB_W-1:0] DEF_FG = 3'b010,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             frame_tick,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [6:0]       wr_char,
  input  logic [RGB_W-1:0] wr_fg,
  input  logic [RGB_W-1:0] wr_bg,
  input  logic             mv_right,
  input  logic             mv_down,
  output logic [6:0]       cur_x,
  output logic [4:0]       cur_y,
  output logic             busy,
  output logic [RGB_W-1:0] rgb_text
);
  localparam int DW = 7 + 2 * RGB_W;
  localparam logic [6:0] LAST_X = 7'(MAX_X - 1);
  localparam logic [4:0] LAST_Y = 5'(MAX_Y - 1);
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t r_state, w_state_nx;
  logic [6:0] r_cur_x, w_cur_x_nx, r_clr_x, w_clr_x_nx;
  logic [4:0] r_cur_y, w_cur_y_nx, r_clr_y, w_clr_y_nx;
  logic [5:0] w_y_sum, w_y_wrap;
  logic [4:0] w_y_inc;
  logic w_acc, w_cr, w_lf, w_ff, w_print, w_mv_r, w_mv_d, w_adv, w_x_end, w_clr_x_end, w_clr_done;
  logic w_cur_vis;
  assign busy     = r_state == S_CLEAR;
  assign wr_ready = r_state == S_IDLE;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;
  assign w_acc    = wr_valid & wr_ready;
  assign w_cr     = wr_char == 7'h0D;
  assign w_lf     = wr_char == 7'h0A;
  assign w_ff     = wr_char == 7'h0C;
  assign w_print  = w_acc & ~(w_cr | w_lf | w_ff);
  // move ticks only count in IDLE and lose to an accepted write
  assign w_mv_r   = wr_ready & ~w_acc & mv_right;
  assign w_mv_d   = wr_ready & ~w_acc & mv_down;
  assign w_adv    = w_print | w_mv_r;
  assign w_x_end  = r_cur_x == LAST_X;
  assign w_y_inc  = (r_cur_y == LAST_Y) ? 5'd0 : r_cur_y + 5'd1;
  // column-wrap carry and a down tick can both land in one cycle, so add then fold once
  assign w_y_sum  = {1'b0, r_cur_y} + {5'd0, w_adv & w_x_end} + {5'd0, w_mv_d};
  assign w_y_wrap = (w_y_sum >= 6'(MAX_Y)) ? w_y_sum - 6'(MAX_Y) : w_y_sum;
  assign w_clr_x_end = r_clr_x == LAST_X;
  assign w_clr_done  = w_clr_x_end & (r_clr_y == LAST_Y);
  always_comb begin
    w_state_nx = busy ? (w_clr_done ? S_IDLE : S_CLEAR) : ((w_acc & w_ff) ? S_CLEAR : S_IDLE);
    w_cur_x_nx = (w_acc & ~w_print) ? 7'd0 : w_adv ? (w_x_end ? 7'd0 : r_cur_x + 7'd1) : r_cur_x;
    w_cur_y_nx = (w_acc & w_ff) ? 5'd0 : (w_acc & w_lf) ? w_y_inc : w_y_wrap[4:0];
    w_clr_x_nx = (busy & ~w_clr_x_end) ? r_clr_x + 7'd1 : 7'd0;
    w_clr_y_nx = (~busy | w_clr_done) ? 5'd0 : w_clr_x_end ? r_clr_y + 5'd1 : r_clr_y;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_clr_x <= '0;
      r_clr_y <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cur_x <= w_cur_x_nx;
      r_cur_y <= w_cur_y_nx;
      r_clr_x <= w_clr_x_nx;
      r_clr_y <= w_clr_y_nx;
    end
  end
  logic [DW-1:0] r_mem [0:4095];
  logic          w_we;
  logic [11:0]   w_waddr, w_raddr;
  logic [DW-1:0] w_wdata;
  assign w_we    = busy | w_print;
  assign w_waddr = busy ? {r_clr_y, r_clr_x} : {r_cur_y, r_cur_x};
  assign w_wdata = busy ? {7'h00, DEF_FG, {RGB_W{1'b0}}} : {wr_char, wr_fg, wr_bg};
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
`ifdef CURSOR_BLINK_EN
  logic [15:0] r_blink_cnt;
  logic        r_cur_vis;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_cur_vis   <= 1'b1;
    end else if (w_acc | w_mv_r | w_mv_d) begin
      r_blink_cnt <= '0;
      r_cur_vis   <= 1'b1;
    end else if (frame_tick) begin
      r_blink_cnt <= (r_blink_cnt == 16'(BLINK_FRAMES - 1)) ? 16'd0 : r_blink_cnt + 16'd1;
      r_cur_vis   <= (r_blink_cnt == 16'(BLINK_FRAMES - 1)) ? ~r_cur_vis : r_cur_vis;
    end
  end
  assign w_cur_vis = r_cur_vis;
`else
  logic w_unused;
  assign w_unused  = ^{frame_tick, 32'(BLINK_FRAMES)};
  assign w_cur_vis = 1'b1;
`endif
  logic          w_oog, w_on_cur, w_bit;
  logic [7:0]    w_font;
  logic [DW-1:0] r_rd;
  logic [3:0]    r_y1;
  logic [2:0]    r_x1, r_x2;
  logic          r_vid1, r_oog1, r_cur1, r_vid2, r_oog2, r_cur2;
  logic [7:0]    r_font;
  logic [RGB_W-1:0] r_fg2, r_bg2, w_fg, w_bg;
  assign w_raddr  = {pixel_y[8:4], pixel_x[9:3]};
  assign w_oog    = pixel_y[9] | ({1'b0, pixel_x[9:3]} >= 8'(MAX_X)) | ({1'b0, pixel_y[8:4]} >= 6'(MAX_Y));
  assign w_on_cur = (pixel_x[9:3] == r_cur_x) & (pixel_y[8:4] == r_cur_y);
  font_rom u_font (.addr({r_rd[DW-1 -: 7], r_y1}), .data(w_font));
  assign w_bit = r_font[~r_x2];
  assign w_fg  = r_cur2 ? r_bg2 : r_fg2;
  assign w_bg  = r_cur2 ? r_fg2 : r_bg2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd     <= '0;
      r_y1     <= '0;
      r_x1     <= '0;
      r_vid1   <= 1'b0;
      r_oog1   <= 1'b0;
      r_cur1   <= 1'b0;
      r_font   <= '0;
      r_x2     <= '0;
      r_fg2    <= '0;
      r_bg2    <= '0;
      r_vid2   <= 1'b0;
      r_oog2   <= 1'b0;
      r_cur2   <= 1'b0;
      rgb_text <= '0;
    end else begin
      r_rd     <= r_mem[w_raddr];
      r_y1     <= pixel_y[3:0];
      r_x1     <= pixel_x[2:0];
      r_vid1   <= video_on;
      r_oog1   <= w_oog;
      r_cur1   <= w_on_cur & w_cur_vis;
      r_font   <= w_font;
      r_x2     <= r_x1;
      r_fg2    <= r_rd[2*RGB_W-1:RGB_W];
      r_bg2    <= r_rd[RGB_W-1:0];
      r_vid2   <= r_vid1;
      r_oog2   <= r_oog1;
      r_cur2   <= r_cur1;
      rgb_text <= (r_vid2 & ~r_oog2) ? (w_bit ? w_fg : w_bg) : '0;
    end
  end
endmodule

// File: tb/tb_text_tile_gen.sv
// tb_text_tile_gen: directed bench for text_tile_gen (80x30 grid, 3-bit colour, blink half-period 2)
module tb_text_tile_gen;
  logic clk = 0, reset = 1, video_on = 0, frame_tick = 0, wr_valid = 0, mv_right = 0, mv_down = 0;
  logic [9:0] pixel_x = 0, pixel_y = 0;
  logic [6:0] wr_char = 0;
  logic [2:0] wr_fg = 0, wr_bg = 0;
  logic wr_ready, busy;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic [2:0] rgb_text;
  int checks = 0, errors = 0;
  text_tile_gen #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char),
    .wr_fg(wr_fg), .wr_bg(wr_bg), .mv_right(mv_right), .mv_down(mv_down),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .rgb_text(rgb_text)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input int x, input int y, input logic v);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = v;
    repeat (3) tick();
  endtask
  task automatic wr(input logic [6:0] c, input logic [2:0] f, input logic [2:0] b);
    wr_valid = 1; wr_char = c; wr_fg = f; wr_bg = b;
    tick();
    wr_valid = 0;
  endtask
  task automatic mv(input logic r, input logic d, input int n);
    repeat (n) begin
      mv_right = r; mv_down = d;
      tick();
    end
    mv_right = 0; mv_down = 0;
  endtask
  task automatic test_reset();
    int n;
    int bad;
    logic [11:0] a;
    pix(8, 0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", wr_ready); end
    checks++; if ({cur_x, cur_y} !== 12'd0) begin errors++; $display("FAIL rst_cursor got %0d,%0d exp 0,0", cur_x, cur_y); end
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL rst_rgb got %b exp 000", rgb_text); end
    reset = 0;
    n = 0;
    while (!wr_ready && n < 3000) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got %b exp 1 at %0d", busy, n); end
      tick();
      n++;
    end
    checks++; if (n !== 2400) begin errors++; $display("FAIL clear_len got %0d exp 2400", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    bad = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++) begin
        a = {5'(y), 7'(x)};
        if (dut.r_mem[a] !== 13'b0000000_010_000) bad++;
      end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_cells got %0d bad cells exp 0", bad); end
    pix(3, 5, 1);
    checks++; if (rgb_text !== 3'b010) begin errors++; $display("FAIL clear_cursor_pix got %b exp 010", rgb_text); end
    pix(8, 0, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL clear_cell_pix got %b exp 000", rgb_text); end
  endtask
  task automatic test_write();
    wr(7'h41, 3'b100, 3'b001);
    checks++; if ({cur_x, cur_y} !== {7'd1, 5'd0}) begin errors++; $display("FAIL wr_cursor got %0d,%0d exp 1,0", cur_x, cur_y); end
    pix(640, 0, 1);
    pixel_x = 10'd2; pixel_y = 10'd3;
    repeat (2) tick();
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL lat_early got %b exp 000", rgb_text); end
    tick();
    checks++; if (rgb_text !== 3'b100) begin errors++; $display("FAIL lat_pix got %b exp 100", rgb_text); end
    pix(0, 3, 1);
    checks++; if (rgb_text !== 3'b001) begin errors++; $display("FAIL A_0_3 got %b exp 001", rgb_text); end
    pix(3, 7, 1);
    checks++; if (rgb_text !== 3'b100) begin errors++; $display("FAIL A_3_7 got %b exp 100", rgb_text); end
    pix(7, 7, 1);
    checks++; if (rgb_text !== 3'b001) begin errors++; $display("FAIL A_7_7 got %b exp 001", rgb_text); end
    pix(2, 15, 1);
    checks++; if (rgb_text !== 3'b001) begin errors++; $display("FAIL A_2_15 got %b exp 001", rgb_text); end
    pix(8, 0, 1);
    checks++; if (rgb_text !== 3'b010) begin errors++; $display("FAIL cursor_1_0 got %b exp 010", rgb_text); end
  endtask
  task automatic test_cursor_wrap();
    mv(1, 0, 78);
    checks++; if ({cur_x, cur_y} !== {7'd79, 5'd0}) begin errors++; $display("FAIL mvr_79 got %0d,%0d exp 79,0", cur_x, cur_y); end
    mv(0, 1, 28);
    mv(1, 1, 1);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin errors++; $display("FAIL mv_both got %0d,%0d exp 0,0", cur_x, cur_y); end
    mv(1, 0, 79);
    mv(0, 1, 29);
    checks++; if ({cur_x, cur_y} !== {7'd79, 5'd29}) begin errors++; $display("FAIL mv_corner got %0d,%0d exp 79,29", cur_x, cur_y); end
    wr(7'h42, 3'b111, 3'b000);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin errors++; $display("FAIL wr_wrap got %0d,%0d exp 0,0", cur_x, cur_y); end
    pix(634, 466, 1);
    checks++; if (rgb_text !== 3'b111) begin errors++; $display("FAIL B_corner got %b exp 111", rgb_text); end
    wr(7'h0A, 3'b000, 3'b000);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd1}) begin errors++; $display("FAIL lf got %0d,%0d exp 0,1", cur_x, cur_y); end
    mv(1, 0, 3);
    wr(7'h0D, 3'b000, 3'b000);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd1}) begin errors++; $display("FAIL cr got %0d,%0d exp 0,1", cur_x, cur_y); end
    pix(24, 16, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL cr_nowrite got %b exp 000", rgb_text); end
    mv(0, 1, 28);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd29}) begin errors++; $display("FAIL mvd_29 got %0d,%0d exp 0,29", cur_x, cur_y); end
    mv(0, 1, 1);
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin errors++; $display("FAIL mvd_wrap got %0d,%0d exp 0,0", cur_x, cur_y); end
  endtask
  task automatic test_same_cycle();
    mv(0, 1, 3);
    mv(1, 0, 5);
    wr_valid = 1; wr_char = 7'h41; wr_fg = 3'b110; wr_bg = 3'b011; mv_right = 1;
    tick();
    wr_valid = 0; mv_right = 0;
    checks++; if ({cur_x, cur_y} !== {7'd6, 5'd3}) begin errors++; $display("FAIL same_cursor got %0d,%0d exp 6,3", cur_x, cur_y); end
    pix(42, 51, 1);
    checks++; if (rgb_text !== 3'b110) begin errors++; $display("FAIL same_fg got %b exp 110", rgb_text); end
    pix(40, 51, 1);
    checks++; if (rgb_text !== 3'b011) begin errors++; $display("FAIL same_bg got %b exp 011", rgb_text); end
  endtask
  task automatic test_out_of_grid();
    pix(640, 3, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL oog_x got %b exp 000", rgb_text); end
    pix(2, 480, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL oog_y got %b exp 000", rgb_text); end
    pix(2, 3, 0);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL video_off got %b exp 000", rgb_text); end
    pix(2, 3, 1);
    checks++; if (rgb_text !== 3'b100) begin errors++; $display("FAIL video_on got %b exp 100", rgb_text); end
  endtask
  task automatic test_form_feed();
    int n;
    wr_valid = 1; wr_char = 7'h0C; wr_fg = 3'b000; wr_bg = 3'b000;
    tick();
    wr_char = 7'h41; wr_fg = 3'b101;
    checks++; if ({busy, wr_ready} !== 2'b10) begin errors++; $display("FAIL ff_state got busy %b ready %b exp 1 0", busy, wr_ready); end
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin errors++; $display("FAIL ff_cursor got %0d,%0d exp 0,0", cur_x, cur_y); end
    n = 0;
    while (!wr_ready && n < 3000) begin
      tick();
      n++;
    end
    checks++; if (n !== 2400) begin errors++; $display("FAIL ff_len got %0d exp 2400", n); end
    checks++; if ({cur_x, cur_y} !== {7'd0, 5'd0}) begin errors++; $display("FAIL ff_held got %0d,%0d exp 0,0", cur_x, cur_y); end
    tick();
    wr_valid = 0;
    checks++; if ({cur_x, cur_y} !== {7'd1, 5'd0}) begin errors++; $display("FAIL ff_accept got %0d,%0d exp 1,0", cur_x, cur_y); end
    pix(42, 51, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL ff_cleared got %b exp 000", rgb_text); end
    pix(2, 3, 1);
    checks++; if (rgb_text !== 3'b101) begin errors++; $display("FAIL ff_written got %b exp 101", rgb_text); end
  endtask
`ifdef CURSOR_BLINK_EN
  task automatic test_blink();
    pix(8, 0, 1);
    checks++; if (rgb_text !== 3'b010) begin errors++; $display("FAIL blink_on got %b exp 010", rgb_text); end
    repeat (2) begin frame_tick = 1; tick(); frame_tick = 0; tick(); end
    pix(8, 0, 1);
    checks++; if (rgb_text !== 3'b000) begin errors++; $display("FAIL blink_off got %b exp 000", rgb_text); end
    repeat (2) begin frame_tick = 1; tick(); frame_tick = 0; tick(); end
    pix(8, 0, 1);
    checks++; if (rgb_text !== 3'b010) begin errors++; $display("FAIL blink_back got %b exp 010", rgb_text); end
  endtask
`endif
  initial begin
    tick();
    tick();
    test_reset();
    test_write();
    test_cursor_wrap();
    test_same_cycle();
    test_out_of_grid();
    test_form_feed();
`ifdef CURSOR_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
